key_entry: RTL and testbench

Numeric entry stage that sits directly downstream of the 4x4 keypad scanner on the DE2 board. It consumes the scanner's 4-bit key code and key-valid strobe, and assembles up to DIGITS decimal digits into a BCD entry buffer. It supports backspace, clear and enter keys. A committed value is presented on a valid/ready handshake toward the application, and the live buffer drives the seven-segment display path.

---
 rtl/key_entry_pkg.sv | 21 ++
 rtl/key_entry_if.sv | 26 ++
 rtl/key_entry_tick_1ms.sv | 30 +++
 rtl/key_entry.sv | 145 ++++++++++++++
 tb/tb_key_entry.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/key_entry_pkg.sv
// Shared key codes, entry-state encoding and BCD digit width for the keypad entry path.
package key_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [3:0] KEY_BKSP = 4'hA;
    localparam logic [3:0] KEY_CLR  = 4'hB;
    localparam logic [3:0] KEY_ENT  = 4'hC;

    typedef enum logic [1:0] {
        EMPTY,
        ENTRY,
        FULL,
        PEND
    } state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/key_entry_if.sv
// Scanner input, display path and committed-value handshake of the key entry stage.
interface key_entry_if #(
    parameter int unsigned DIGITS = 4
) ();
    import key_pkg::*;

    logic [3:0]              key_data;
    logic                    key_flag;
    logic [BCD_W*DIGITS-1:0] disp_val;
    logic [3:0]              disp_len;
    logic [BCD_W*DIGITS-1:0] out_val;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err;

    modport master (
        output key_data, key_flag, out_ready,
        input  disp_val, disp_len, out_val, out_valid, err
    );

    modport slave (
        input  key_data, key_flag, out_ready,
        output disp_val, disp_len, out_val, out_valid, err
    );

endinterface

// File: rtl/key_entry_tick_1ms.sv
// Free-running divider producing a one-cycle pulse every CLK_HZ/1000 clocks.
module key_tick_1ms #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int unsigned DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/key_entry.sv
// Keypad numeric entry: BCD buffer with backspace/clear/enter and a valid/ready commit port.
// Optional inactivity timeout enabled by defining KEY_ENTRY_TIMEOUT_EN.
module key_entry
    import key_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TIMEOUT_MS = 5000
) (
    input  logic      clk,
    input  logic      rst_n,
    key_entry_if.slave bus
);
    localparam int unsigned W = BCD_W * DIGITS;

    if (DIGITS < 2 || DIGITS > 8 || CLK_HZ < 1000 || TIMEOUT_MS == 0) begin : g_bad_cfg
        $error("key_entry: unsupported parameter set");
    end

    state_e      state_q, state_d;
    logic [W-1:0] disp_q, disp_d;
    logic [W-1:0] out_q, out_d;
    logic [3:0]   len_q, len_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;
    logic         flag_q;
    logic         press;
    logic         timeout;

    assign press = bus.key_flag & ~flag_q;

`ifdef KEY_ENTRY_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_MS + 1);

    logic          tick;
    logic [TW-1:0] idle_q, idle_d;

    key_tick_1ms #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Idle count only runs while a partial entry is on display.
    always_comb begin
        idle_d  = idle_q;
        timeout = 1'b0;
        if (press || !(state_q inside {ENTRY, FULL})) begin
            idle_d = '0;
        end else if (tick) begin
            if (idle_q == TW'(TIMEOUT_MS - 1)) begin
                timeout = 1'b1;
                idle_d  = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    always_comb timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        len_d   = len_q;
        out_d   = out_q;
        valid_d = valid_q;
        err_d   = 1'b0;

        if (state_q == PEND) begin
            if (press) err_d = 1'b1;
            if (valid_q && bus.out_ready) begin
                valid_d = 1'b0;
                state_d = EMPTY;
            end
        end else if (press) begin
            if (is_digit(bus.key_data)) begin
                if (state_q == FULL) begin
                    err_d = 1'b1;
                end else begin
                    disp_d  = {disp_q[W-BCD_W-1:0], bus.key_data};
                    len_d   = len_q + 4'd1;
                    state_d = (len_d == 4'(DIGITS)) ? FULL : ENTRY;
                end
            end else if (bus.key_data == KEY_BKSP) begin
                if (len_q != 4'd0) begin
                    disp_d  = {{BCD_W{1'b0}}, disp_q[W-1:BCD_W]};
                    len_d   = len_q - 4'd1;
                    state_d = (len_d == 4'd0) ? EMPTY : ENTRY;
                end
            end else if (bus.key_data == KEY_CLR) begin
                disp_d  = '0;
                len_d   = '0;
                state_d = EMPTY;
            end else if (bus.key_data == KEY_ENT) begin
                if (len_q != 4'd0) begin
                    out_d   = disp_q;
                    valid_d = 1'b1;
                    disp_d  = '0;
                    len_d   = '0;
                    state_d = PEND;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (timeout) begin
            disp_d  = '0;
            len_d   = '0;
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            disp_q  <= '0;
            len_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            len_q   <= len_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            flag_q  <= bus.key_flag;
        end
    end

    assign bus.disp_val  = disp_q;
    assign bus.disp_len  = len_q;
    assign bus.out_val   = out_q;
    assign bus.out_valid = valid_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_key_entry.sv
// Scoreboard bench for key_entry: expectations queued by the driver, checked by a monitor.
module tb_key_entry;
    import key_pkg::*;

    localparam int unsigned DIG = 4;
`ifdef KEY_ENTRY_TIMEOUT_EN
    localparam int unsigned HOLD = 8;
`else
    localparam int unsigned HOLD = 100;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_entry_if #(.DIGITS(DIG)) bus ();

    key_entry #(
        .DIGITS     (DIG),
        .CLK_HZ     (1000),
        .TIMEOUT_MS (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  len;
    } disp_t;

    disp_t       disp_q[$];
    logic [15:0] out_q[$];
    logic [3:0]  err_q[$];
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        checks++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    task automatic exp_disp(input logic [15:0] v, input logic [3:0] l);
        disp_q.push_back('{val: v, len: l});
    endtask

    task automatic press(input logic [3:0] k, input int unsigned hold = 1);
        @(negedge clk);
        bus.key_data = k;
        bus.key_flag = 1'b1;
        repeat (hold) @(negedge clk);
        bus.key_flag = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: samples just after the falling edge, away from DUT updates and driver writes.
    initial begin
        disp_t prev, cur, e;
        logic [15:0] ov;
        logic [3:0]  el;
        prev = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev = '0;
                continue;
            end
            cur = {bus.disp_val, bus.disp_len};
            if (cur != prev) begin
                if (disp_q.size() == 0) fail("disp_change", 32'(cur));
                else begin
                    e = disp_q.pop_front();
                    check("disp", 32'(cur), 32'(e));
                end
                prev = cur;
            end
            if (bus.err) begin
                if (err_q.size() == 0) fail("err_pulse", 32'(bus.disp_len));
                else begin
                    el = err_q.pop_front();
                    check("err_len", 32'(bus.disp_len), 32'(el));
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (out_q.size() == 0) fail("transfer", 32'(bus.out_val));
                else begin
                    ov = out_q.pop_front();
                    check("out_val", 32'(bus.out_val), 32'(ov));
                end
            end
        end
    end

    initial begin
        bus.key_data  = 4'h0;
        bus.key_flag  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_disp_val", 32'(bus.disp_val), 32'h0);
        check("rst_disp_len", 32'(bus.disp_len), 32'h0);
        check("rst_out_val", 32'(bus.out_val), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);

        // 1,2,3 ENTER, commit held until out_ready
        exp_disp(16'h0001, 4'd1); press(4'h1);
        exp_disp(16'h0012, 4'd2); press(4'h2);
        exp_disp(16'h0123, 4'd3); press(4'h3);
        exp_disp(16'h0000, 4'd0); press(KEY_ENT);
        repeat (5) @(negedge clk);
        check("pend_valid", 32'(bus.out_valid), 32'h1);
        check("pend_val", 32'(bus.out_val), 32'h0123);
        out_q.push_back(16'h0123);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("ack_valid", 32'(bus.out_valid), 32'h0);
        check("held_out_val", 32'(bus.out_val), 32'h0123);

        // Overflow: fifth digit rejected
        exp_disp(16'h0009, 4'd1); press(4'h9);
        exp_disp(16'h0098, 4'd2); press(4'h8);
        exp_disp(16'h0987, 4'd3); press(4'h7);
        exp_disp(16'h9876, 4'd4); press(4'h6);
        err_q.push_back(4'd4);    press(4'h5);
        exp_disp(16'h0000, 4'd0); press(KEY_CLR);

        // Backspace, clear, empty enter, ignored code, empty backspace
        exp_disp(16'h0004, 4'd1); press(4'h4);
        exp_disp(16'h0045, 4'd2); press(4'h5);
        exp_disp(16'h0004, 4'd1); press(KEY_BKSP);
        exp_disp(16'h0000, 4'd0); press(KEY_CLR);
        err_q.push_back(4'd0);    press(KEY_ENT);
        press(4'hE);
        press(KEY_BKSP);
        check("empty_enter_valid", 32'(bus.out_valid), 32'h0);

        // Long strobe gives a single action
        exp_disp(16'h0007, 4'd1); press(4'h7, HOLD);
        check("hold_len", 32'(bus.disp_len), 32'h1);
        exp_disp(16'h0000, 4'd0); press(KEY_CLR);

        // Press coincides with transfer in PEND
        exp_disp(16'h0003, 4'd1); press(4'h3);
        exp_disp(16'h0000, 4'd0); press(KEY_ENT);
        out_q.push_back(16'h0003);
        err_q.push_back(4'd0);
        @(negedge clk);
        bus.key_data  = 4'h3;
        bus.key_flag  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.key_flag  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("sim_valid", 32'(bus.out_valid), 32'h0);
        check("sim_len", 32'(bus.disp_len), 32'h0);

        // Reset while PEND discards the pending value
        exp_disp(16'h0005, 4'd1); press(4'h5);
        exp_disp(16'h0000, 4'd0); press(KEY_ENT);
        check("pre_rst_valid", 32'(bus.out_valid), 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'h0);
        check("async_rst_out_val", 32'(bus.out_val), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef KEY_ENTRY_TIMEOUT_EN
        exp_disp(16'h0002, 4'd1); press(4'h2);
        exp_disp(16'h0000, 4'd0);
        repeat (20) @(negedge clk);
        check("timeout_len", 32'(bus.disp_len), 32'h0);
`endif

        repeat (3) @(negedge clk);
        check("disp_q_drained", 32'(disp_q.size()), 32'h0);
        check("out_q_drained", 32'(out_q.size()), 32'h0);
        check("err_q_drained", 32'(err_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
